// File: rtl/alternate_seq_ctrl.sv
// rtl/alternate_seq_ctrl.sv - word-to-bit sequencer for the serial alternate-pattern checker
// Optional feature macro: ALT_SEQ_STATS_EN (adds stat_words / stat_pass counters)
module alternate_seq_ctrl #(
    parameter int WIDTH   = 32,
    parameter int CHK_LAT = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_word,
    output logic             in_ready,
    input  logic             abort,
    output logic             chk_rst_n,
    output logic             bit_out,
    output logic             bit_valid,
    input  logic             chk_check,
    output logic             res_valid,
    output logic             res_pass,
    input  logic             res_ready
`ifdef ALT_SEQ_STATS_EN
    ,
    output logic [15:0]      stat_words,
    output logic [15:0]      stat_pass
`endif
);

    localparam int CW = $clog2(WIDTH);
    localparam int LW = (CHK_LAT > 1) ? $clog2(CHK_LAT) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLR,
        S_SHIFT,
        S_WAIT,
        S_DONE
    } state_t;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] sreg, sreg_nxt;
    logic [CW-1:0]    cnt, cnt_nxt;
    logic [LW-1:0]    lat, lat_nxt;
    logic             in_ready_nxt, chk_rst_n_nxt, bit_out_nxt, bit_valid_nxt;
    logic             res_valid_nxt, res_pass_nxt;
`ifdef ALT_SEQ_STATS_EN
    logic [15:0]      stat_words_nxt, stat_pass_nxt;
`endif

    // State and every output are registered together; the comb block decides their next values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            sreg       <= '0;
            cnt        <= '0;
            lat        <= '0;
            in_ready   <= 1'b1;
            chk_rst_n  <= 1'b1;
            bit_out    <= 1'b0;
            bit_valid  <= 1'b0;
            res_valid  <= 1'b0;
            res_pass   <= 1'b0;
`ifdef ALT_SEQ_STATS_EN
            stat_words <= '0;
            stat_pass  <= '0;
`endif
        end else begin
            state      <= state_nxt;
            sreg       <= sreg_nxt;
            cnt        <= cnt_nxt;
            lat        <= lat_nxt;
            in_ready   <= in_ready_nxt;
            chk_rst_n  <= chk_rst_n_nxt;
            bit_out    <= bit_out_nxt;
            bit_valid  <= bit_valid_nxt;
            res_valid  <= res_valid_nxt;
            res_pass   <= res_pass_nxt;
`ifdef ALT_SEQ_STATS_EN
            stat_words <= stat_words_nxt;
            stat_pass  <= stat_pass_nxt;
`endif
        end
    end

    // Next-state and next-output decode; abort beats a simultaneous last SHIFT/WAIT edge.
    always_comb begin
        state_nxt     = state;
        sreg_nxt      = sreg;
        cnt_nxt       = cnt;
        lat_nxt       = lat;
        in_ready_nxt  = in_ready;
        chk_rst_n_nxt = chk_rst_n;
        bit_out_nxt   = bit_out;
        bit_valid_nxt = bit_valid;
        res_valid_nxt = res_valid;
        res_pass_nxt  = res_pass;
`ifdef ALT_SEQ_STATS_EN
        stat_words_nxt = stat_words;
        stat_pass_nxt  = stat_pass;
`endif
        if (abort && (state == S_CLR || state == S_SHIFT || state == S_WAIT)) begin
            state_nxt     = S_IDLE;
            in_ready_nxt  = 1'b1;
            chk_rst_n_nxt = 1'b1;
            bit_out_nxt   = 1'b0;
            bit_valid_nxt = 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (in_valid) begin
                        state_nxt     = S_CLR;
                        sreg_nxt      = in_word;
                        cnt_nxt       = CW'(WIDTH - 1);
                        in_ready_nxt  = 1'b0;
                        chk_rst_n_nxt = 1'b0;
                    end
                end
                S_CLR: begin
                    state_nxt     = S_SHIFT;
                    chk_rst_n_nxt = 1'b1;
                    bit_valid_nxt = 1'b1;
                    bit_out_nxt   = sreg[WIDTH-1];
                    sreg_nxt      = {sreg[WIDTH-2:0], 1'b0};
                end
                S_SHIFT: begin
                    if (cnt == '0) begin
                        state_nxt     = S_WAIT;
                        bit_valid_nxt = 1'b0;
                        bit_out_nxt   = 1'b0;
                        lat_nxt       = LW'(CHK_LAT - 1);
                    end else begin
                        cnt_nxt     = cnt - 1'b1;
                        bit_out_nxt = sreg[WIDTH-1];
                        sreg_nxt    = {sreg[WIDTH-2:0], 1'b0};
                    end
                end
                S_WAIT: begin
                    if (lat == '0) begin
                        state_nxt     = S_DONE;
                        res_valid_nxt = 1'b1;
                        res_pass_nxt  = chk_check;
                    end else begin
                        lat_nxt = lat - 1'b1;
                    end
                end
                S_DONE: begin
                    if (res_ready) begin
                        state_nxt     = S_IDLE;
                        res_valid_nxt = 1'b0;
                        in_ready_nxt  = 1'b1;
`ifdef ALT_SEQ_STATS_EN
                        if (stat_words != 16'hFFFF) stat_words_nxt = stat_words + 16'd1;
                        if (res_pass && stat_pass != 16'hFFFF) stat_pass_nxt = stat_pass + 16'd1;
`endif
                    end
                end
                default: begin
                    state_nxt     = S_IDLE;
                    in_ready_nxt  = 1'b1;
                    chk_rst_n_nxt = 1'b1;
                    bit_out_nxt   = 1'b0;
                    bit_valid_nxt = 1'b0;
                    res_valid_nxt = 1'b0;
                end
            endcase
        end
    end

endmodule
